// File: rtl/mul_writeback_if.sv
// Issue / multiplier-return / writeback bundle for mul_writeback.
// The slave modport is the writeback block; the master modport is the core-side driver.
interface mul_writeback_if #(
  parameter int DATA_SIZE = 32,
  parameter int TAG_W     = 5
);
  logic                   issue_valid;
  logic [1:0]             issue_op;
  logic [TAG_W-1:0]       issue_tag;
  logic                   issue_credit;
  logic                   mul_ready;
  logic [2*DATA_SIZE-1:0] mul_result;
  logic                   wb_valid;
  logic                   wb_ready;
  logic [DATA_SIZE-1:0]   wb_data;
  logic [TAG_W-1:0]       wb_tag;
  logic                   wb_sat;
  logic                   err_sticky;

  modport master (
    output issue_valid, issue_op, issue_tag, mul_ready, mul_result, wb_ready,
    input  issue_credit, wb_valid, wb_data, wb_tag, wb_sat, err_sticky
  );

  modport slave (
    input  issue_valid, issue_op, issue_tag, mul_ready, mul_result, wb_ready,
    output issue_credit, wb_valid, wb_data, wb_tag, wb_sat, err_sticky
  );
endinterface

// File: rtl/mul_writeback.sv
// Multiplier writeback: tracks issued ops alongside the multiplier, formats products and buffers them.
// Define MUL_WB_SAT_EN to enable rounding and saturation of SMUL results.
module mul_writeback #(
  parameter int DATA_SIZE  = 32,
  parameter int MUL_LAT    = 3,
  parameter int FIFO_DEPTH = 4,
  parameter int TAG_W      = 5
) (
  input logic             clk,
  input logic             rst_n,
  mul_writeback_if.slave  bus
);

  localparam int PW    = 2 * DATA_SIZE;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
  localparam int INF_W = $clog2(MUL_LAT + 1);
  localparam int SUM_W = $clog2(FIFO_DEPTH + MUL_LAT + 1);
  localparam int ENT_W = DATA_SIZE + TAG_W + 1;

  typedef enum logic [1:0] {
    OP_MUL  = 2'b00,
    OP_MULH = 2'b01,
    OP_SMUL = 2'b10,
    OP_RSVD = 2'b11
  } op_e;

  logic [MUL_LAT-1:0] stgVld_q;
  op_e                stgOp_q  [MUL_LAT];
  logic [TAG_W-1:0]   stgTag_q [MUL_LAT];

  logic [ENT_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic             err_q, err_d;

  logic [INF_W-1:0]     inFlight;
  logic                 credit;
  logic                 issueAcc;
  logic                 lastVld;
  op_e                  lastOp;
  logic                 full;
  logic                 push;
  logic                 pop;
  logic [DATA_SIZE-1:0] resData;
  logic                 resSat;
  logic [ENT_W-1:0]     head;

  function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    inFlight = '0;
    for (int i = 0; i < MUL_LAT; i++) begin
      inFlight = inFlight + INF_W'(stgVld_q[i]);
    end
  end

  // Credit is conservative: a slot freed by a pop only counts from the next cycle.
  assign credit   = (SUM_W'(occ_q) + SUM_W'(inFlight)) < SUM_W'(FIFO_DEPTH);
  assign issueAcc = bus.issue_valid & credit;
  assign lastVld  = stgVld_q[MUL_LAT-1];
  assign lastOp   = stgOp_q[MUL_LAT-1];
  assign full     = (occ_q == OCC_W'(FIFO_DEPTH));
  assign pop      = (occ_q != '0) & bus.wb_ready;
  assign push     = lastVld & bus.mul_ready & (~full | pop);

`ifdef MUL_WB_SAT_EN
  localparam logic [PW:0] RND_C = (PW + 1)'(1) << (DATA_SIZE - 2);

  logic [PW:0] rndSum;
  logic        satPos;
  logic        satNeg;
  logic        unusedRndLsb;

  // Result fits only when the top three bits of the rounded sum agree.
  assign rndSum       = {bus.mul_result[PW-1], bus.mul_result} + RND_C;
  assign satPos       = ~rndSum[PW] & (rndSum[PW-1] | rndSum[PW-2]);
  assign satNeg       = rndSum[PW] & ~(rndSum[PW-1] & rndSum[PW-2]);
  assign unusedRndLsb = ^rndSum[DATA_SIZE-2:0];
`endif

  always_comb begin
    resData = bus.mul_result[DATA_SIZE-1:0];
    resSat  = 1'b0;
    case (lastOp)
      OP_MULH: resData = bus.mul_result[PW-1:DATA_SIZE];
      OP_SMUL: begin
`ifdef MUL_WB_SAT_EN
        if (satPos) begin
          resData = {1'b0, {(DATA_SIZE-1){1'b1}}};
          resSat  = 1'b1;
        end else if (satNeg) begin
          resData = {1'b1, {(DATA_SIZE-1){1'b0}}};
          resSat  = 1'b1;
        end else begin
          resData = rndSum[PW-2:DATA_SIZE-1];
        end
`else
        resData = bus.mul_result[PW-2:DATA_SIZE-1];
`endif
      end
      default: ;
    endcase
  end

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    occ_d   = occ_q;
    err_d   = err_q;
    if (push) wrPtr_d = nextPtr(wrPtr_q);
    if (pop)  rdPtr_d = nextPtr(rdPtr_q);
    case ({push, pop})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: ;
    endcase
    // Dropped issues, unmatched returns and lost results all latch the error flag.
    if (bus.issue_valid & ~credit)                  err_d = 1'b1;
    if (bus.mul_ready ^ lastVld)                    err_d = 1'b1;
    if (lastVld & bus.mul_ready & full & ~pop)      err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stgVld_q <= '0;
      wrPtr_q  <= '0;
      rdPtr_q  <= '0;
      occ_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      stgVld_q[0] <= issueAcc;
      for (int i = 1; i < MUL_LAT; i++) begin
        stgVld_q[i] <= stgVld_q[i-1];
      end
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      occ_q   <= occ_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    stgOp_q[0]  <= op_e'(bus.issue_op);
    stgTag_q[0] <= bus.issue_tag;
    for (int i = 1; i < MUL_LAT; i++) begin
      stgOp_q[i]  <= stgOp_q[i-1];
      stgTag_q[i] <= stgTag_q[i-1];
    end
    if (push) begin
      mem_q[wrPtr_q] <= {resSat, stgTag_q[MUL_LAT-1], resData};
    end
  end

  assign head             = mem_q[rdPtr_q];
  assign bus.wb_valid     = (occ_q != '0);
  assign bus.wb_data      = head[DATA_SIZE-1:0];
  assign bus.wb_tag       = head[DATA_SIZE +: TAG_W];
  assign bus.wb_sat       = head[ENT_W-1];
  assign bus.issue_credit = credit;
  assign bus.err_sticky   = err_q;

endmodule

// File: tb/tb_mul_writeback.sv
// Scoreboard bench for mul_writeback: models the multiplier delay line and predicts formatted results.
// Build with MUL_WB_SAT_EN defined to check the saturating SMUL variant.
module tb_mul_writeback;

  localparam int DATA_SIZE  = 32;
  localparam int MUL_LAT    = 3;
  localparam int FIFO_DEPTH = 4;
  localparam int TAG_W      = 5;

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  tag;
    logic        sat;
  } exp_t;

  typedef struct packed {
    logic [31:0] due;
    logic [63:0] res;
  } mulJob_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  mul_writeback_if #(.DATA_SIZE(DATA_SIZE), .TAG_W(TAG_W)) bus ();

  mul_writeback #(
    .DATA_SIZE (DATA_SIZE),
    .MUL_LAT   (MUL_LAT),
    .FIFO_DEPTH(FIFO_DEPTH),
    .TAG_W     (TAG_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  exp_t    sbQ  [$];
  mulJob_t mulQ [$];
  int          checkCount = 0;
  int          errorCount = 0;
  logic [31:0] cyc = 0;
  logic        rstNext = 1'b0;
  logic        wbValidSeen;
  logic        creditSeen;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  function automatic exp_t modelResult(input logic [1:0] op, input logic [4:0] tag, input logic [63:0] p);
    exp_t e;
`ifdef MUL_WB_SAT_EN
    logic signed [64:0] wide;
    logic signed [64:0] shifted;
`endif
    e     = '0;
    e.tag = tag;
    case (op)
      2'b01: e.data = p[63:32];
      2'b10: begin
`ifdef MUL_WB_SAT_EN
        wide    = $signed({p[63], p}) + 65'sd1073741824;
        shifted = wide >>> 31;
        if (shifted > 65'sd2147483647) begin
          e.data = 32'h7FFFFFFF;
          e.sat  = 1'b1;
        end else if (shifted < -65'sd2147483648) begin
          e.data = 32'h80000000;
          e.sat  = 1'b1;
        end else begin
          e.data = shifted[31:0];
        end
`else
        e.data = p[62:31];
`endif
      end
      default: e.data = p[31:0];
    endcase
    return e;
  endfunction

  // One clock cycle: sample outputs, drive inputs, feed the multiplier model and score any pop.
  task automatic applyStimulus(input logic iv, input logic [1:0] op, input logic [4:0] tag,
                               input logic [63:0] prod, input logic rdy);
    logic    expCredit;
    exp_t    head;
    mulJob_t job;
    @(negedge clk);
    wbValidSeen = bus.wb_valid;
    creditSeen  = bus.issue_credit;
    expCredit   = (sbQ.size() < FIFO_DEPTH);
    rst_n       = rstNext;
    if (iv && rstNext) checkOutput("issue_credit", bus.issue_credit, expCredit);
    bus.issue_valid = iv;
    bus.issue_op    = op;
    bus.issue_tag   = tag;
    if (iv && expCredit) begin
      sbQ.push_back(modelResult(op, tag, prod));
      job.due = cyc + MUL_LAT;
      job.res = prod;
      mulQ.push_back(job);
    end
    if (mulQ.size() > 0 && mulQ[0].due == cyc) begin
      job            = mulQ.pop_front();
      bus.mul_ready  = 1'b1;
      bus.mul_result = job.res;
    end else begin
      bus.mul_ready  = 1'b0;
      bus.mul_result = {$urandom, $urandom};
    end
    bus.wb_ready = rdy;
    if (rstNext && bus.wb_valid && rdy) begin
      if (sbQ.size() == 0) begin
        checkOutput("wb_unexpected", 1, 0);
      end else begin
        head = sbQ.pop_front();
        checkOutput("wb_data", bus.wb_data, head.data);
        checkOutput("wb_tag", bus.wb_tag, head.tag);
        checkOutput("wb_sat", bus.wb_sat, head.sat);
      end
    end
    if (!rstNext) sbQ.delete();
    cyc++;
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 2'b00, 5'd0, 64'd0, rdy);
  endtask

  task automatic drain();
    idle(12, 1'b1);
    checkOutput("sb_empty", sbQ.size(), 0);
  endtask

  initial begin
    logic signed [31:0] a, b;
    logic signed [63:0] prodS;
    logic               iv;
    logic [1:0]         op;
    logic [4:0]         tagCnt;

    bus.issue_valid = 1'b0;
    bus.issue_op    = 2'b00;
    bus.issue_tag   = '0;
    bus.mul_ready   = 1'b0;
    bus.mul_result  = '0;
    bus.wb_ready    = 1'b0;

    rstNext = 1'b0;
    idle(3, 1'b0);
    checkOutput("rst_wb_valid", wbValidSeen, 0);
    rstNext = 1'b1;
    idle(2, 1'b0);
    checkOutput("rst_credit", creditSeen, 1);
    checkOutput("rst_err", bus.err_sticky, 0);

    // Basic latency: issue in cycle 0, valid in cycle MUL_LAT+1.
    applyStimulus(1'b1, 2'b00, 5'd3, 64'h00000002_00000005, 1'b1);
    idle(3, 1'b1);
    checkOutput("lat_early", wbValidSeen, 0);
    idle(1, 1'b1);
    checkOutput("lat_valid", wbValidSeen, 1);
    drain();

    applyStimulus(1'b1, 2'b01, 5'd7, 64'hFFFFFFFF_FFFFFFFE, 1'b1);
    drain();

    applyStimulus(1'b1, 2'b10, 5'd9,  64'h40000000_00000000, 1'b1);
    applyStimulus(1'b1, 2'b10, 5'd10, 64'h80000000_00000000, 1'b1);
    applyStimulus(1'b1, 2'b10, 5'd11, 64'hC0000000_00000000, 1'b1);
    applyStimulus(1'b1, 2'b11, 5'd12, 64'h12345678_9ABCDEF0, 1'b1);
    drain();
    applyStimulus(1'b1, 2'b10, 5'd13, 64'h00000000_40000000, 1'b1);
    applyStimulus(1'b1, 2'b10, 5'd14, 64'h00000000_3FFFFFFF, 1'b1);
    drain();

    // Random legal traffic with random consumer back-pressure.
    for (int i = 0; i < 40; i++) begin
      a     = $urandom;
      b     = $urandom;
      prodS = a * b;
      op    = 2'($urandom_range(0, 3));
      iv    = (sbQ.size() < FIFO_DEPTH) && ($urandom_range(0, 3) != 0);
      applyStimulus(iv, op, 5'(i), prodS, $urandom_range(0, 3) != 0);
    end
    drain();
    checkOutput("err_clean", bus.err_sticky, 0);

    // Back-pressure: four issues fill the credit, the fifth is dropped.
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 2'b00, 5'(20 + i), 64'(100 + i), 1'b0);
    applyStimulus(1'b1, 2'b00, 5'd24, 64'd999, 1'b0);
    idle(1, 1'b0);
    checkOutput("drop_err", bus.err_sticky, 1);
    idle(3, 1'b0);
    checkOutput("full_valid", wbValidSeen, 1);
    drain();

    rstNext = 1'b0;
    idle(2, 1'b0);
    rstNext = 1'b1;
    idle(1, 1'b0);
    checkOutput("err_cleared", bus.err_sticky, 0);

    // Keep the buffer saturated while draining so the pointers wrap several times.
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 2'b01, 5'(i), {32'(i + 1), 32'h0}, 1'b0);
    idle(3, 1'b0);
    checkOutput("sat_credit", bus.issue_credit, 0);
    tagCnt = 5'd4;
    for (int i = 0; i < 24; i++) begin
      iv = (sbQ.size() < FIFO_DEPTH);
      applyStimulus(iv, 2'b00, tagCnt, {32'hDEAD0000, 32'(i)}, 1'b1);
      if (iv) tagCnt = tagCnt + 5'd1;
    end
    drain();
    checkOutput("stream_err", bus.err_sticky, 0);

    // Reset with two ops in flight: results vanish and the late return is flagged.
    applyStimulus(1'b1, 2'b00, 5'd30, 64'd55, 1'b1);
    applyStimulus(1'b1, 2'b01, 5'd31, 64'd66, 1'b1);
    rstNext = 1'b0;
    idle(1, 1'b1);
    rstNext = 1'b1;
    for (int i = 0; i < 4; i++) begin
      idle(1, 1'b1);
      checkOutput("rst_wb_hold", wbValidSeen, 0);
    end
    checkOutput("stray_err", bus.err_sticky, 1);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
